// File: rtl/iir_pkg.sv
// Shared defaults and helpers for the iir_requant requantiser.
package iir_pkg;

  localparam int DEF_IN_W   = 36;
  localparam int DEF_SHIFT  = 14;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_WIDE_W = 18;
  localparam int DEF_NCH    = 4;

  // Channel tag width: never narrower than one bit, even for a single channel.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iir_requant_clamp.sv
// requant_clamp: combinational signed clamp from IN_W bits down to OUT_W bits.
// sat is high exactly when the clamp altered the value.
module requant_clamp #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  if (IN_W > OUT_W) begin : g_clamp
    // Bits above the output sign bit must all equal it, otherwise the value is out of range.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = din[IN_W-1:OUT_W-1];

    // Pass through when in range, otherwise pick the rail matching the input sign.
    always_comb begin
      dout = din[OUT_W-1:0];
      sat  = 1'b0;
      if (!((&top_bits) || !(|top_bits))) begin
        sat  = 1'b1;
        dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end else begin : g_pass
    assign dout = OUT_W'(din);
    assign sat  = 1'b0;
  end

endmodule

// File: rtl/iir_requant.sv
// iir_requant: two-stage requantiser (arithmetic shift, then clamp) with
// per-channel sticky saturation flags and a saturating clamp counter.
// Build option: define IIR_REQUANT_ROUND_EN for round-half-up instead of floor.
//
// Handshake: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and payload until it transfers, and ready may depend
// combinationally on the downstream ready.
module iir_requant
  import iir_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int WIDE_W = DEF_WIDE_W,
  parameter int NCH    = DEF_NCH,
  localparam int CH_W  = ch_w(NCH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [IN_W-1:0]   s_data,
  input  logic [CH_W-1:0]          s_ch,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data_sat,
  output logic [WIDE_W-1:0]        m_data_wide,
  output logic [CH_W-1:0]          m_ch,
  output logic                     m_sat,
  input  logic                     clr_sat,
  output logic [NCH-1:0]           sat_flags,
  output logic [15:0]              sat_count
);

  localparam int SW = IN_W - SHIFT;

  logic signed [SW-1:0] shifted;

`ifdef IIR_REQUANT_ROUND_EN
  logic signed [IN_W:0]    rnd_sum;
  logic signed [IN_W-SHIFT:0] rnd_q;
  logic                    unused_rnd_lsb;

  // Round half up: add half an LSB in one extra bit, then drop the fraction.
  // Only the most positive inputs can round past the SW-bit range; pin those to max.
  always_comb begin
    rnd_sum = {s_data[IN_W-1], s_data} + ((IN_W+1)'(1) << (SHIFT-1));
    rnd_q   = rnd_sum[IN_W:SHIFT];
    shifted = rnd_q[SW-1:0];
    if (rnd_q[SW] != rnd_q[SW-1]) begin
      shifted = {1'b0, {(SW-1){1'b1}}};
    end
  end
  assign unused_rnd_lsb = ^rnd_sum[SHIFT-1:0];
`else
  logic unused_floor_lsb;
  // Floor shift is just the upper bits of the two's-complement sample.
  assign shifted          = s_data[IN_W-1:SHIFT];
  assign unused_floor_lsb = ^s_data[SHIFT-1:0];
`endif

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_shift_q, s1_shift_d;
  logic [CH_W-1:0]      s1_ch_q,    s1_ch_d;

  // Stage 2 (output) state
  logic                    m_valid_q,     m_valid_d;
  logic signed [OUT_W-1:0] m_data_sat_q,  m_data_sat_d;
  logic [WIDE_W-1:0]       m_data_wide_q, m_data_wide_d;
  logic [CH_W-1:0]         m_ch_q,        m_ch_d;
  logic                    m_sat_q,       m_sat_d;

  // Saturation bookkeeping
  logic [NCH-1:0] sat_flags_q, sat_flags_d;
  logic [15:0]    sat_count_q, sat_count_d;

  logic signed [OUT_W-1:0] clamp_data;
  logic                    clamp_sat;
  logic                    s2_adv;
  logic                    s1_ready;
  logic                    sat_event;

  requant_clamp #(
    .IN_W  (SW),
    .OUT_W (OUT_W)
  ) u_clamp (
    .din  (s1_shift_q),
    .dout (clamp_data),
    .sat  (clamp_sat)
  );

  // Stage 2 can take a new beat when it is empty or its beat leaves this cycle;
  // stage 1 likewise frees up whenever its beat moves into stage 2.
  assign s2_adv    = !m_valid_q || m_ready;
  assign s1_ready  = !s1_valid_q || s2_adv;
  assign sat_event = m_valid_q && m_ready && m_sat_q;

  // Pipeline next-state: payloads only change on load, so a stalled output holds.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_shift_d    = s1_shift_q;
    s1_ch_d       = s1_ch_q;
    m_valid_d     = m_valid_q;
    m_data_sat_d  = m_data_sat_q;
    m_data_wide_d = m_data_wide_q;
    m_ch_d        = m_ch_q;
    m_sat_d       = m_sat_q;
    if (s1_ready) begin
      s1_valid_d = s_valid;
      if (s_valid) begin
        s1_shift_d = shifted;
        s1_ch_d    = s_ch;
      end
    end
    if (s2_adv) begin
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_sat_d  = clamp_data;
        m_data_wide_d = WIDE_W'(s1_shift_q);
        m_ch_d        = s1_ch_q;
        m_sat_d       = clamp_sat;
      end
    end
  end

  // Sticky flags and counter: clear first, so a same-cycle clamped transfer still lands.
  always_comb begin
    sat_flags_d = clr_sat ? '0 : sat_flags_q;
    sat_count_d = clr_sat ? 16'd0 : sat_count_q;
    for (int i = 0; i < NCH; i++) begin
      if (sat_event && (int'(m_ch_q) == i)) begin
        sat_flags_d[i] = 1'b1;
      end
    end
    if (sat_event && (sat_count_d != 16'hFFFF)) begin
      sat_count_d = sat_count_d + 16'd1;
    end
  end

  // State registers; reset drops any in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_shift_q    <= '0;
      s1_ch_q       <= '0;
      m_valid_q     <= 1'b0;
      m_data_sat_q  <= '0;
      m_data_wide_q <= '0;
      m_ch_q        <= '0;
      m_sat_q       <= 1'b0;
      sat_flags_q   <= '0;
      sat_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_shift_q    <= s1_shift_d;
      s1_ch_q       <= s1_ch_d;
      m_valid_q     <= m_valid_d;
      m_data_sat_q  <= m_data_sat_d;
      m_data_wide_q <= m_data_wide_d;
      m_ch_q        <= m_ch_d;
      m_sat_q       <= m_sat_d;
      sat_flags_q   <= sat_flags_d;
      sat_count_q   <= sat_count_d;
    end
  end

  assign s_ready     = s1_ready;
  assign m_valid     = m_valid_q;
  assign m_data_sat  = m_data_sat_q;
  assign m_data_wide = m_data_wide_q;
  assign m_ch        = m_ch_q;
  assign m_sat       = m_sat_q;
  assign sat_flags   = sat_flags_q;
  assign sat_count   = sat_count_q;

endmodule

// File: tb/tb_iir_requant.sv
// Bench for iir_requant at default parameters (either rounding build).
module tb_iir_requant;

  localparam int EW = 16 + 18 + 2 + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [35:0] s_data;
  logic [1:0]         s_ch;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_data_sat;
  logic [17:0]        m_data_wide;
  logic [1:0]         m_ch;
  logic               m_sat;
  logic               clr_sat;
  logic [3:0]         sat_flags;
  logic [15:0]        sat_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];

  // Reference state for the sticky flags and counter
  logic [3:0]  ref_flags;
  logic [15:0] ref_count;

  logic rand_ready = 1'b0;

  iir_requant dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_ch        (s_ch),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data_sat  (m_data_sat),
    .m_data_wide (m_data_wide),
    .m_ch        (m_ch),
    .m_sat       (m_sat),
    .clr_sat     (clr_sat),
    .sat_flags   (sat_flags),
    .sat_count   (sat_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Shift as integer division by 2^14 rounded toward minus infinity.
  function automatic longint ref_shift(input longint d);
    longint x;
    x = d;
`ifdef IIR_REQUANT_ROUND_EN
    x = x + 64'sd8192;
`endif
    if (x >= 0) return x / 16384;
    return -((-x + 16383) / 16384);
  endfunction

  function automatic logic [EW-1:0] make_exp(input logic signed [35:0] d, input logic [1:0] ch);
    longint q;
    longint c;
    logic   sat;
    logic [63:0] qb;
    logic [63:0] cb;
    q   = ref_shift(longint'(d));
    c   = q;
    sat = 1'b0;
    if (q > 32767) begin
      c = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      c = -32768; sat = 1'b1;
    end
    qb = q;
    cb = c;
    return {cb[15:0], qb[17:0], ch, sat};
  endfunction

  function automatic logic signed [35:0] rand_data();
    logic [63:0] r;
    longint      b;
    int          mode;
    mode = $urandom_range(0, 2);
    if (mode == 0) begin
      r = {$urandom, $urandom};
      return r[35:0];
    end else if (mode == 1) begin
      b = longint'($urandom_range(32760, 32775)) * 16384 + longint'($urandom_range(0, 16383));
      if ($urandom_range(0, 1) == 1) b = -b;
      return 36'(b);
    end
    return 36'(longint'($urandom_range(0, 65535)) - 32768);
  endfunction

  function automatic logic signed [35:0] rand_sat_data();
    longint b;
    b = longint'($urandom_range(32768, 40000)) * 16384 + longint'($urandom_range(0, 16383));
    if ($urandom_range(0, 1) == 1) b = -b - 16384;
    return 36'(b);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic signed [35:0] d, input logic [1:0] ch);
    int   waitc;
    logic acc;
    s_valid = 1'b1;
    s_data  = d;
    s_ch    = ch;
    waitc   = 0;
    acc     = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1'b1;
        exp_q.push_back(make_exp(d, ch));
      end
      tick();
      if (!acc) begin
        waitc++;
        if (waitc > 500) begin
          n_cmp++;
          n_err++;
          $display("FAIL send_timeout: sample %0h not accepted", d);
          acc = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 2000) begin
      tick();
      waitc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic check_sat(input string tag);
    chk({tag, "_flags"}, 64'(sat_flags), 64'(ref_flags));
    chk({tag, "_count"}, 64'(sat_count), 64'(ref_count));
  endtask

  // Randomised downstream ready when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic          stall_prev = 1'b0;
  logic [EW:0]   snap;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    logic          hs;
    act = {m_data_sat, m_data_wide, m_ch, m_sat};
    if (rst) begin
      stall_prev = 1'b0;
      ref_flags  = 4'b0;
      ref_count  = 16'd0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if ({m_valid, act} !== snap) begin
          n_err++;
          $display("FAIL stall_stable: got %0h held %0h", {m_valid, act}, snap);
        end
      end
      hs = 1'b0;
      e  = '0;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none", act);
        end else begin
          e  = exp_q.pop_front();
          hs = 1'b1;
          if (act !== e) begin
            n_err++;
            $display("FAIL output: got sat=%0h wide=%0h ch=%0d m_sat=%0b expected sat=%0h wide=%0h ch=%0d m_sat=%0b",
                     m_data_sat, m_data_wide, m_ch, m_sat, e[36:21], e[20:3], e[2:1], e[0]);
          end
        end
      end
      // State the flags/counter will hold after the coming edge
      if (clr_sat) begin
        ref_flags = 4'b0;
        ref_count = 16'd0;
      end
      if (hs && e[0]) begin
        ref_flags[e[2:1]] = 1'b1;
        if (ref_count != 16'hFFFF) ref_count = ref_count + 16'd1;
      end
      stall_prev = m_valid && !m_ready;
      snap       = {m_valid, act};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waitc;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_ch    = '0;
    m_ready = 1'b1;
    clr_sat = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_data_sat", 64'(m_data_sat), 64'd0);
    chk("rst_m_data_wide", 64'(m_data_wide), 64'd0);
    chk("rst_m_ch", 64'(m_ch), 64'd0);
    chk("rst_m_sat", 64'(m_sat), 64'd0);
    chk("rst_sat_flags", 64'(sat_flags), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);

    // Negative clamp on channel 2
    send(-36'sd536887296, 2'd2);
    drain();
    chk("neg_clamp_flags", 64'(sat_flags), 64'h4);
    chk("neg_clamp_count", 64'(sat_count), 64'd1);

    // Positive boundary and rounding corner values
    send(36'sd536854528, 2'd0);
    send(36'sd536870912, 2'd0);
    send(36'sd8192, 2'd3);
    send(-36'sd8192, 2'd3);
    send(36'sd0, 2'd1);
    send(-36'sd1, 2'd1);
    drain();
    check_sat("directed");

    // Random traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rand_data(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) tick();
    end
    rand_ready = 1'b0;
    #2;
    m_ready = 1'b1;
    drain();
    check_sat("random");

    // Backpressure: three offered, two accepted, outputs held
    m_ready = 1'b0;
    send(36'sd1638400, 2'd0);
    send(-36'sd3276800, 2'd1);
    s_valid = 1'b1;
    s_data  = 36'sd4915200;
    s_ch    = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      tick();
    end
    m_ready = 1'b1;
    send(36'sd4915200, 2'd2);
    drain();

    // Reset mid-stream discards everything in flight
    m_ready = 1'b0;
    send(36'sd123456789, 2'd1);
    send(-36'sd987654321, 2'd3);
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    chk("midrst_flags", 64'(sat_flags), 64'd0);
    repeat (4) tick();
    chk("midrst_no_output", 64'(m_valid), 64'd0);

    // Set another flag, then clear in the same cycle as a clamped transfer on ch 1
    send(36'sd600000000, 2'd3);
    drain();
    check_sat("pre_clr");
    m_ready = 1'b0;
    send(36'sd600000000, 2'd1);
    waitc = 0;
    while (!m_valid && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("clr_wait_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    chk("clr_event_flags", 64'(sat_flags), 64'h2);
    chk("clr_event_count", 64'(sat_count), 64'd1);
    drain();

    // Counter saturation
    for (int i = 0; i < 65536; i++) begin
      send(rand_sat_data(), 2'd1);
    end
    drain();
    chk("count_ceiling", 64'(sat_count), 64'hFFFF);
    chk("count_ceiling_flags", 64'(sat_flags), 64'h2);
    check_sat("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
